param_register_bank: RTL and testbench

- Parametrised bank of NREG general-purpose registers, each WIDTH bits, with a shared 4-bit function select.
- Next-generation datapath register block for the CPU register file and address registers.
- Adds shift/rotate, saturating arithmetic, multi-register simultaneous update, two asynchronous read ports and sticky per-register wrap flags.
- Single clock domain; all register updates occur on the rising edge of Clock.

---
 rtl/param_register_bank.sv | 149 ++++++++++++++
 tb/tb_param_register_bank.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/param_register_bank.sv
// param_register_bank: a bank of NREG general-purpose registers, each WIDTH bits
// wide. Every selected register executes the same 4-bit function in the same
// cycle. There are two combinational read ports and one sticky wrap flag per
// register.
//
// Ports:
//   Clock    - rising-edge clock
//   Reset_n  - asynchronous active-low reset; loads RESET_VAL and clears Wrap
//   E        - global enable; 0 holds every register
//   RegSel   - per-register write select (one bit per register)
//   FunSel   - operation code applied to each selected register
//   I        - data input
//   OutASel  - read port A register index
//   OutBSel  - read port B register index
//   OutA     - combinational read of register OutASel (0 if the index is out of range)
//   OutB     - combinational read of register OutBSel (0 if the index is out of range)
//   Wrap     - sticky per-register wrap flags (registered)
module param_register_bank #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned NREG      = 4,
  parameter int unsigned SELW      = $clog2(NREG),
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              E,
  input  logic [NREG-1:0]   RegSel,
  input  logic [3:0]        FunSel,
  input  logic [WIDTH-1:0]  I,
  input  logic [SELW-1:0]   OutASel,
  input  logic [SELW-1:0]   OutBSel,
  output logic [WIDTH-1:0]  OutA,
  output logic [WIDTH-1:0]  OutB,
  output logic [NREG-1:0]   Wrap
);

  localparam int unsigned HALF = WIDTH / 2;
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ALL_ZERO = '0;

  localparam logic [3:0] OP_HOLD  = 4'b0000;
  localparam logic [3:0] OP_DEC   = 4'b0001;
  localparam logic [3:0] OP_INC   = 4'b0010;
  localparam logic [3:0] OP_LOAD  = 4'b0011;
  localparam logic [3:0] OP_CLR   = 4'b0100;
  localparam logic [3:0] OP_LOZX  = 4'b0101;
  localparam logic [3:0] OP_LOLO  = 4'b0110;
  localparam logic [3:0] OP_LOHI  = 4'b0111;
  localparam logic [3:0] OP_SEXT  = 4'b1000;
  localparam logic [3:0] OP_SHL   = 4'b1001;
  localparam logic [3:0] OP_SHR   = 4'b1010;
  localparam logic [3:0] OP_ASR   = 4'b1011;
  localparam logic [3:0] OP_ROL   = 4'b1100;
  localparam logic [3:0] OP_ROR   = 4'b1101;
  localparam logic [3:0] OP_SINC  = 4'b1110;
  localparam logic [3:0] OP_SDEC  = 4'b1111;

  logic [WIDTH-1:0] regs      [NREG];
  logic [WIDTH-1:0] regs_next [NREG];
  logic [NREG-1:0]  wrap_q;
  logic [NREG-1:0]  wrap_next;

  // Result of one operation applied to a single register value q.
  function automatic logic [WIDTH-1:0] op_result(
    input logic [WIDTH-1:0] q,
    input logic [3:0]       f,
    input logic [WIDTH-1:0] d
  );
    logic [WIDTH-1:0] r;
    r = q;
    case (f)
      OP_HOLD: r = q;
      OP_DEC:  r = q - WIDTH'(1);
      OP_INC:  r = q + WIDTH'(1);
      OP_LOAD: r = d;
      OP_CLR:  r = ALL_ZERO;
      OP_LOZX: r = {{HALF{1'b0}}, d[HALF-1:0]};
      OP_LOLO: r = {q[WIDTH-1:HALF], d[HALF-1:0]};
      OP_LOHI: r = {d[WIDTH-1:HALF], q[HALF-1:0]};
      OP_SEXT: r = {{HALF{d[HALF-1]}}, d[HALF-1:0]};
      OP_SHL:  r = {q[WIDTH-2:0], 1'b0};
      OP_SHR:  r = {1'b0, q[WIDTH-1:1]};
      OP_ASR:  r = {q[WIDTH-1], q[WIDTH-1:1]};
      OP_ROL:  r = {q[WIDTH-2:0], q[WIDTH-1]};
      OP_ROR:  r = {q[0], q[WIDTH-1:1]};
      OP_SINC: r = (q == ALL_ONES) ? q : q + WIDTH'(1);
      OP_SDEC: r = (q == ALL_ZERO) ? q : q - WIDTH'(1);
      default: r = q;
    endcase
    return r;
  endfunction

  // Next-state for every register and its wrap flag; unselected registers hold.
  always_comb begin
    for (int k = 0; k < NREG; k++) begin
      regs_next[k] = regs[k];
      wrap_next[k] = wrap_q[k];
      if (E && RegSel[k]) begin
        regs_next[k] = op_result(regs[k], FunSel, I);
        // Only the modular inc/dec can wrap; clear is the only way to drop the flag.
        if (FunSel == OP_CLR) begin
          wrap_next[k] = 1'b0;
        end else if (FunSel == OP_DEC && regs[k] == ALL_ZERO) begin
          wrap_next[k] = 1'b1;
        end else if (FunSel == OP_INC && regs[k] == ALL_ONES) begin
          wrap_next[k] = 1'b1;
        end
      end
    end
  end

  // Register array and wrap flags.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int k = 0; k < NREG; k++) begin
        regs[k] <= RESET_VAL;
      end
      wrap_q <= '0;
    end else begin
      for (int k = 0; k < NREG; k++) begin
        regs[k] <= regs_next[k];
      end
      wrap_q <= wrap_next;
    end
  end

  // Read port A: out-of-range index reads as zero.
  always_comb begin
    OutA = '0;
    for (int k = 0; k < NREG; k++) begin
      if (OutASel == SELW'(k)) begin
        OutA = regs[k];
      end
    end
  end

  // Read port B: out-of-range index reads as zero.
  always_comb begin
    OutB = '0;
    for (int k = 0; k < NREG; k++) begin
      if (OutBSel == SELW'(k)) begin
        OutB = regs[k];
      end
    end
  end

  assign Wrap = wrap_q;

endmodule

// File: tb/tb_param_register_bank.sv
// Scoreboarded bench for param_register_bank (WIDTH=16, NREG=4). The stimulus
// process updates an arithmetic reference model and queues the expected
// post-edge view. A separate monitor pops and compares that view after every
// rising edge.
module tb_param_register_bank;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned NREG  = 4;
  localparam int unsigned SELW  = 2;
  localparam int unsigned M     = 65536;
  localparam int unsigned H     = 256;

  logic              Clock;
  logic              Reset_n;
  logic              E;
  logic [NREG-1:0]   RegSel;
  logic [3:0]        FunSel;
  logic [WIDTH-1:0]  I;
  logic [SELW-1:0]   OutASel;
  logic [SELW-1:0]   OutBSel;
  logic [WIDTH-1:0]  OutA;
  logic [WIDTH-1:0]  OutB;
  logic [NREG-1:0]   Wrap;

  param_register_bank #(.WIDTH(WIDTH), .NREG(NREG)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .E(E), .RegSel(RegSel), .FunSel(FunSel),
    .I(I), .OutASel(OutASel), .OutBSel(OutBSel), .OutA(OutA), .OutB(OutB), .Wrap(Wrap)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [NREG-1:0]  w;
  } exp_t;

  exp_t        sb[$];
  int unsigned mregs[NREG];
  bit   [NREG-1:0] mwrap;
  int          vectors = 0;
  int          miscompares = 0;

  // Reference behaviour of one op in plain modular arithmetic.
  function automatic int unsigned model_op(int unsigned q, int unsigned f, int unsigned d);
    int unsigned lo;
    lo = d % H;
    case (f)
      0:  return q;
      1:  return (q + M - 1) % M;
      2:  return (q + 1) % M;
      3:  return d;
      4:  return 0;
      5:  return lo;
      6:  return (q / H) * H + lo;
      7:  return (d / H) * H + q % H;
      8:  return (lo >= H / 2) ? lo + M - H : lo;
      9:  return (q * 2) % M;
      10: return q / 2;
      11: return q / 2 + ((q >= M / 2) ? M / 2 : 0);
      12: return (q * 2) % M + q / (M / 2);
      13: return q / 2 + (q % 2) * (M / 2);
      14: return (q == M - 1) ? q : q + 1;
      default: return (q == 0) ? 0 : q - 1;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NREG; k++) mregs[k] = 0;
    mwrap = '0;
  endtask

  // Drive one cycle of inputs, advance the model, and queue the post-edge expectation.
  task automatic apply(input logic e_in, input logic [NREG-1:0] rs, input logic [3:0] f,
                       input logic [WIDTH-1:0] d, input logic [SELW-1:0] sa,
                       input logic [SELW-1:0] sbl);
    exp_t ex;
    @(posedge Clock);
    #3;
    E = e_in; RegSel = rs; FunSel = f; I = d; OutASel = sa; OutBSel = sbl;
    if (e_in) begin
      for (int k = 0; k < NREG; k++) begin
        if (rs[k]) begin
          if (f == 4'd4) mwrap[k] = 1'b0;
          else if (f == 4'd1 && mregs[k] == 0) mwrap[k] = 1'b1;
          else if (f == 4'd2 && mregs[k] == M - 1) mwrap[k] = 1'b1;
          mregs[k] = model_op(mregs[k], int'(f), int'(d));
        end
      end
    end
    ex.a = WIDTH'(mregs[sa]);
    ex.b = WIDTH'(mregs[sbl]);
    ex.w = mwrap;
    sb.push_back(ex);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge Clock);
      n++;
    end
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: after each rising edge, compare the outputs against the oldest expectation.
  initial begin
    exp_t ex;
    forever begin
      @(posedge Clock);
      #1;
      if (sb.size() != 0) begin
        ex = sb.pop_front();
        check("outa", 32'(OutA), 32'(ex.a));
        check("outb", 32'(OutB), 32'(ex.b));
        check("wrap", 32'(Wrap), 32'(ex.w));
      end
    end
  end

  initial begin
    Reset_n = 1'b0; E = 1'b0; RegSel = '0; FunSel = '0; I = '0; OutASel = '0; OutBSel = '0;
    model_reset();
    repeat (3) @(posedge Clock);
    #1;
    check("reset_outa", 32'(OutA), 32'h0);
    check("reset_wrap", 32'(Wrap), 32'h0);
    @(negedge Clock);
    Reset_n = 1'b1;

    // Load register 0, then assert reset mid-cycle and expect an immediate clear.
    apply(1, 4'b0001, 4'd3, 16'hA5C3, 2'd0, 2'd1);
    drain();
    check("load_a5c3", 32'(OutA), 32'hA5C3);
    @(posedge Clock);
    #3;
    E = 1'b0;
    #2;
    Reset_n = 1'b0;
    #1;
    check("async_reset", 32'(OutA), 32'h0);
    model_reset();
    @(posedge Clock);
    #1;
    check("reset_held", 32'(OutA), 32'h0);
    @(negedge Clock);
    Reset_n = 1'b1;

    // Wrap on decrement and increment; only clear drops the flag.
    apply(1, 4'b0010, 4'd4, 16'h0, 2'd1, 2'd0);
    apply(1, 4'b0010, 4'd1, 16'h0, 2'd1, 2'd0);
    apply(1, 4'b0010, 4'd2, 16'h0, 2'd1, 2'd0);
    apply(1, 4'b0010, 4'd2, 16'h0, 2'd1, 2'd0);
    drain();
    check("wrap_sticky", 32'(Wrap), 32'h2);
    apply(1, 4'b0010, 4'd4, 16'h0, 2'd1, 2'd0);

    // Shifts and rotates from 8001.
    for (int f = 10; f <= 13; f++) begin
      apply(1, 4'b0100, 4'd3, 16'h8001, 2'd2, 2'd2);
      apply(1, 4'b0100, 4'(f), 16'h0, 2'd2, 2'd2);
    end
    drain();
    check("ror_8001", 32'(OutA), 32'hC000);

    // Saturating increment and decrement never wrap.
    apply(1, 4'b0001, 4'd3, 16'hFFFE, 2'd0, 2'd0);
    repeat (3) apply(1, 4'b0001, 4'd14, 16'h0, 2'd0, 2'd0);
    apply(1, 4'b0001, 4'd3, 16'h0001, 2'd0, 2'd0);
    repeat (2) apply(1, 4'b0001, 4'd15, 16'h0, 2'd0, 2'd0);

    // Half-word and sign-extending loads.
    apply(1, 4'b0001, 4'd8, 16'h1280, 2'd0, 2'd0);
    drain();
    check("sext_1280", 32'(OutA), 32'hFF80);
    apply(1, 4'b0001, 4'd5, 16'h1280, 2'd0, 2'd0);
    apply(1, 4'b0001, 4'd3, 16'h3456, 2'd0, 2'd0);
    apply(1, 4'b0001, 4'd7, 16'h1280, 2'd0, 2'd0);
    apply(1, 4'b0001, 4'd3, 16'h3456, 2'd0, 2'd0);
    apply(1, 4'b0001, 4'd6, 16'h1280, 2'd0, 2'd0);

    // Simultaneous increment of all registers, then enable low.
    apply(1, 4'b1111, 4'd4, 16'h0, 2'd0, 2'd3);
    apply(1, 4'b0010, 4'd3, 16'h0001, 2'd0, 2'd3);
    apply(1, 4'b0100, 4'd3, 16'h0002, 2'd0, 2'd3);
    apply(1, 4'b1000, 4'd3, 16'hFFFF, 2'd0, 2'd3);
    apply(1, 4'b1111, 4'd2, 16'h0, 2'd3, 2'd3);
    apply(0, 4'b1111, 4'd2, 16'h0, 2'd3, 2'd3);
    apply(1, 4'b0000, 4'd3, 16'h1234, 2'd3, 2'd3);
    drain();
    check("all_inc_r3", 32'(OutB), 32'h0);
    check("all_inc_wrap", 32'(Wrap), 32'h8);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      apply(($urandom_range(0, 9) != 0), 4'($urandom), 4'($urandom), 16'($urandom),
            2'($urandom), 2'($urandom));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
